mips_harvard_mem: RTL and testbench

Memory-side responder for the Harvard MIPS CPU's instruction and data ports: a combinational-read instruction ROM window and a combinational-read, single-cycle-write data RAM window. It also owns CPU bring-up. A load FSM accepts program and data images over a valid/ready port, then pulses the CPU reset, runs the CPU with clock enable, and detects halt or timeout. It sits beside the CPU in the simulation top level and in the FPGA wrapper.

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/mips_harvard_mem_if.sv | 49 ++++
 rtl/mips_mem_bank.sv | 27 ++
 rtl/mips_harvard_mem.sv | 161 ++++++++++++++++
 tb/tb_mips_harvard_mem.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the Harvard MIPS memory responder.
// State encoding for the bring-up FSM, default window constants,
// and the window-decode function used by both read ports.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        HALT    = 2'd3
    } mem_state_t;

    localparam logic [31:0] DEF_INSTR_BASE  = 32'hBFC0_0000;
    localparam int          DEF_INSTR_WORDS = 1024;
    localparam logic [31:0] DEF_DATA_BASE   = 32'h0000_0000;
    localparam int          DEF_DATA_WORDS  = 4096;
    localparam logic [31:0] DEF_MAX_CYCLES  = 32'd100000;

    // Decode result: hit flag plus word index relative to the window base.
    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } win_t;

    // Addresses below the base wrap to a huge offset and therefore miss.
    function automatic win_t in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          words);
        win_t        w;
        logic [31:0] off;
        off   = addr - base;
        w.idx = off >> 2;
        w.hit = (w.idx < 32'(words));
        return w;
    endfunction

endpackage

// File: rtl/mips_harvard_mem_if.sv
// Loader, CPU-control and CPU memory-port signals between the responder and its users.
// slave = memory responder side; master = CPU / loader / bench side.
// Clock and reset are carried as plain module ports, not through this bundle.
interface mips_harvard_mem_if;

    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_done;

    logic        cpu_reset;
    logic        cpu_clk_enable;
    logic        cpu_active;

    logic [31:0] instr_address;
    logic [31:0] instr_readdata;

    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic        halted;
    logic        timeout;
    logic        bus_error;
    logic [31:0] cycle_count;

    modport slave (
        input  load_valid, load_sel, load_addr, load_data, load_done,
        input  cpu_active, instr_address,
        input  data_address, data_read, data_write, data_writedata,
        output load_ready, cpu_reset, cpu_clk_enable,
        output instr_readdata, data_readdata,
        output halted, timeout, bus_error, cycle_count
    );

    modport master (
        output load_valid, load_sel, load_addr, load_data, load_done,
        output cpu_active, instr_address,
        output data_address, data_read, data_write, data_writedata,
        input  load_ready, cpu_reset, cpu_clk_enable,
        input  instr_readdata, data_readdata,
        input  halted, timeout, bus_error, cycle_count
    );

endinterface

// File: rtl/mips_mem_bank.sv
// Single memory bank: one asynchronous read port, one synchronous write port.
// Latency: read is combinational; a write is visible on the read port the next cycle.
// Backpressure: none, a write strobe always commits at the clock edge.
module mips_mem_bank #(
    parameter int WORDS = 1024,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [WORDS];

    assign rdata = mem[raddr];

    // Contents are deliberately not reset so images survive a CPU restart.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mips_harvard_mem.sv
// Harvard MIPS memory responder: instruction ROM window, data RAM window, CPU bring-up FSM.
// Latency: reads combinational; data writes and loader words visible one cycle later.
// Backpressure: load_ready is high only in LOAD; the CPU ports never stall.
module mips_harvard_mem
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE  = DEF_INSTR_BASE,
    parameter int          INSTR_WORDS = DEF_INSTR_WORDS,
    parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
    parameter int          DATA_WORDS  = DEF_DATA_WORDS,
    parameter logic [31:0] MAX_CYCLES  = DEF_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    mips_harvard_mem_if.slave bus
);

    localparam int IAW = $clog2(INSTR_WORDS);
    localparam int DAW = $clog2(DATA_WORDS);

    mem_state_t  state;
    logic        seen_active;
    logic        cpu_reset_q;
    logic        clk_enable_q;
    logic        load_ready_q;
    logic        halted_q;
    logic        timeout_q;
    logic        bus_error_q;
    logic [31:0] cycle_count_q;

    win_t        iwin;
    win_t        dwin;
    win_t        dwin_iw;
    logic        in_run;
    logic        instr_ok;
    logic        load_fire;
    logic        cpu_we;
    logic        instr_we;
    logic        data_we;
    logic        instr_err;
    logic        dwr_err;
    logic        drd_err;
    logic        load_err;
    logic        unused_bits;
    logic [DAW-1:0] data_waddr;
    logic [31:0] data_wdata;
    logic [31:0] instr_rdata;
    logic [31:0] data_rdata;

    // Address decode for both CPU ports; dwin_iw catches stores aimed at the ROM window.
    assign iwin     = in_window(bus.instr_address, INSTR_BASE, INSTR_WORDS);
    assign dwin     = in_window(bus.data_address, DATA_BASE, DATA_WORDS);
    assign dwin_iw  = in_window(bus.data_address, INSTR_BASE, INSTR_WORDS);
    assign instr_ok = iwin.hit && (bus.instr_address[1:0] == 2'b00);

    assign in_run    = (state == RUN);
    assign load_fire = (state == LOAD) && bus.load_valid && load_ready_q;
    assign cpu_we    = in_run && clk_enable_q && bus.data_write && dwin.hit && !dwin_iw.hit;

    // Loader always owns the ROM write port; the RAM write port is shared by phase.
    assign instr_we   = load_fire && !bus.load_sel;
    assign data_we    = (load_fire && bus.load_sel) || cpu_we;
    assign data_waddr = (state == LOAD) ? bus.load_addr[DAW-1:0] : dwin.idx[DAW-1:0];
    assign data_wdata = (state == LOAD) ? bus.load_data : bus.data_writedata;

    // Illegal-access sources; each is qualified by the phase in which it counts.
    assign instr_err = in_run && !instr_ok;
    assign dwr_err   = in_run && bus.data_write && (!dwin.hit || dwin_iw.hit);
    assign drd_err   = in_run && bus.data_read && !dwin.hit;
    assign load_err  = load_fire && (bus.load_sel ? (bus.load_addr >= 32'(DATA_WORDS))
                                                  : (bus.load_addr >= 32'(INSTR_WORDS)));

    assign unused_bits = ^{iwin.idx[31:IAW], dwin.idx[31:DAW], dwin_iw.idx};

    mips_mem_bank #(.WORDS(INSTR_WORDS)) u_instr_bank (
        .clk   (clk),
        .raddr (iwin.idx[IAW-1:0]),
        .rdata (instr_rdata),
        .we    (instr_we),
        .waddr (bus.load_addr[IAW-1:0]),
        .wdata (bus.load_data)
    );

    mips_mem_bank #(.WORDS(DATA_WORDS)) u_data_bank (
        .clk   (clk),
        .raddr (dwin.idx[DAW-1:0]),
        .rdata (data_rdata),
        .we    (data_we),
        .waddr (data_waddr),
        .wdata (data_wdata)
    );

    assign bus.instr_readdata = instr_ok ? instr_rdata : 32'h0;
    assign bus.data_readdata  = dwin.hit ? data_rdata  : 32'h0;

    assign bus.load_ready     = load_ready_q;
    assign bus.cpu_reset      = cpu_reset_q;
    assign bus.cpu_clk_enable = clk_enable_q;
    assign bus.halted         = halted_q;
    assign bus.timeout        = timeout_q;
    assign bus.bus_error      = bus_error_q;
    assign bus.cycle_count    = cycle_count_q;

    // Bring-up FSM: load images, hold CPU in reset for one enabled cycle, run, then halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= LOAD;
            seen_active   <= 1'b0;
            cpu_reset_q   <= 1'b1;
            clk_enable_q  <= 1'b0;
            load_ready_q  <= 1'b1;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            bus_error_q   <= 1'b0;
            cycle_count_q <= 32'h0;
        end else begin
            if (instr_err || dwr_err || drd_err || load_err) begin
                bus_error_q <= 1'b1;
            end
            unique case (state)
                LOAD: begin
                    if (bus.load_done) begin
                        state        <= RELEASE;
                        load_ready_q <= 1'b0;
                        clk_enable_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    state       <= RUN;
                    cpu_reset_q <= 1'b0;
                end
                RUN: begin
                    if (cycle_count_q != 32'hFFFF_FFFF) begin
                        cycle_count_q <= cycle_count_q + 32'd1;
                    end
                    if (bus.cpu_active) begin
                        seen_active <= 1'b1;
                    end
                    // Budget exhaustion wins the tie so timeout is flagged.
                    if (cycle_count_q == MAX_CYCLES - 32'd1) begin
                        state        <= HALT;
                        timeout_q    <= 1'b1;
                        clk_enable_q <= 1'b0;
                        halted_q     <= 1'b1;
                    end else if (seen_active && !bus.cpu_active) begin
                        state        <= HALT;
                        clk_enable_q <= 1'b0;
                        halted_q     <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Self-checking bench for mips_harvard_mem: random image loads and stores against an array model,
// directed bring-up, illegal-access, halt, reset and timeout scenarios.
// Outputs are sampled 1 time unit after the rising edge.
module tb_mips_harvard_mem;

    localparam logic [31:0] IBASE = 32'hBFC0_0000;
    localparam int          IW    = 1024;
    localparam logic [31:0] DBASE = 32'h0000_0000;
    localparam int          DW    = 4096;
    localparam int          MAXC  = 50;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;
    int run_cyc;

    // Reference contents of both banks.
    logic [31:0] imem [IW];
    logic [31:0] dmem [DW];

    int lq_sel  [16];
    int lq_addr [16];
    int wr_idx  [6];

    mips_harvard_mem_if bus ();

    mips_harvard_mem #(
        .INSTR_BASE  (IBASE),
        .INSTR_WORDS (IW),
        .DATA_BASE   (DBASE),
        .DATA_WORDS  (DW),
        .MAX_CYCLES  (32'(MAXC))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tick();
        tick();
        run_cyc++;
    endtask

    // Expected instruction word: aligned and inside the ROM window, else zero.
    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        longint la;
        la = longint'(a);
        if (la >= longint'(IBASE) && la < longint'(IBASE) + IW * 4 && (la % 4) == 0)
            return imem[int'((la - longint'(IBASE)) / 4)];
        return 32'h0;
    endfunction

    // Expected data word: byte offset within the word is ignored.
    function automatic logic [31:0] exp_data(input logic [31:0] a);
        longint la;
        la = longint'(a);
        if (la >= longint'(DBASE) && la < longint'(DBASE) + DW * 4)
            return dmem[int'((la - longint'(DBASE)) / 4)];
        return 32'h0;
    endfunction

    task automatic do_load(input logic sel, input logic [31:0] addr,
                           input logic [31:0] dat, input logic done);
        chk("load_ready_before_xfer", bus.load_ready, 32'd1);
        bus.load_valid = 1'b1;
        bus.load_sel   = sel;
        bus.load_addr  = addr;
        bus.load_data  = dat;
        bus.load_done  = done;
        tick();
        bus.load_valid = 1'b0;
        bus.load_done  = 1'b0;
        if (sel) dmem[addr % DW] = dat;
        else     imem[addr % IW] = dat;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_load_ready"}, bus.load_ready,     32'd1);
        chk({tag, "_cpu_reset"},  bus.cpu_reset,      32'd1);
        chk({tag, "_clk_en"},     bus.cpu_clk_enable, 32'd0);
        chk({tag, "_halted"},     bus.halted,         32'd0);
        chk({tag, "_timeout"},    bus.timeout,        32'd0);
        chk({tag, "_bus_error"},  bus.bus_error,      32'd0);
        chk({tag, "_cycles"},     bus.cycle_count,    32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          edges;
        bit          got_halt;

        reset              = 1'b1;
        bus.load_valid     = 1'b0;
        bus.load_sel       = 1'b0;
        bus.load_addr      = 32'h0;
        bus.load_data      = 32'h0;
        bus.load_done      = 1'b0;
        bus.cpu_active     = 1'b0;
        bus.instr_address  = IBASE;
        bus.data_address   = 32'h0;
        bus.data_read      = 1'b0;
        bus.data_write     = 1'b0;
        bus.data_writedata = 32'h0;

        // ---- Reset state ----
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        // ---- Random image loads, read back through both ports ----
        for (int i = 0; i < 16; i++) begin
            lq_sel[i]  = int'($urandom_range(0, 1));
            lq_addr[i] = (lq_sel[i] == 1) ? int'($urandom_range(5, DW - 1))
                                          : int'($urandom_range(1, IW - 1));
            do_load(lq_sel[i][0], 32'(lq_addr[i]), $urandom, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            if (lq_sel[i] == 1) begin
                bus.data_address = DBASE + 32'(lq_addr[i]) * 4 + 32'($urandom_range(0, 3));
                #1;
                chk("load_rand_data", bus.data_readdata, exp_data(bus.data_address));
            end else begin
                bus.instr_address = IBASE + 32'(lq_addr[i]) * 4;
                #1;
                chk("load_rand_instr", bus.instr_readdata, exp_instr(bus.instr_address));
            end
        end
        bus.instr_address = IBASE;

        // ---- Directed loads ----
        do_load(1'b0, 32'd0, 32'h2402_0005, 1'b0);
        chk("load_instr0", bus.instr_readdata, 32'h2402_0005);
        do_load(1'b1, 32'd0, 32'h00C0_FFEE, 1'b0);
        do_load(1'b1, 32'd3, 32'hDEAD_BEEF, 1'b0);
        bus.data_address = 32'h0000_000C;
        #1;
        chk("load_data3_at_C", bus.data_readdata, 32'hDEAD_BEEF);
        bus.data_address = 32'h0000_000E;
        #1;
        chk("load_data3_at_E", bus.data_readdata, 32'hDEAD_BEEF);
        chk("load_no_bus_error", bus.bus_error, 32'd0);

        // Last word rides along with load_done and must still commit; FSM enters RELEASE.
        do_load(1'b1, 32'd4, 32'hA5A5_0004, 1'b1);
        chk("release_cpu_reset",  bus.cpu_reset,      32'd1);
        chk("release_clk_en",     bus.cpu_clk_enable, 32'd1);
        chk("release_load_ready", bus.load_ready,     32'd0);

        tick();
        run_cyc = 0;
        chk("run_cpu_reset", bus.cpu_reset,      32'd0);
        chk("run_clk_en",    bus.cpu_clk_enable, 32'd1);
        chk("run_cycles0",   bus.cycle_count,    32'd0);
        chk("run_instr_at_base", bus.instr_readdata, 32'h2402_0005);

        // ---- Write with simultaneous read: old word now, new word next cycle ----
        bus.cpu_active     = 1'b1;
        bus.data_address   = 32'h0000_0010;
        bus.data_read      = 1'b1;
        bus.data_write     = 1'b1;
        bus.data_writedata = 32'h1234_5678;
        #1;
        chk("rw_same_cycle_old", bus.data_readdata, 32'hA5A5_0004);
        run_tick();
        dmem[4] = 32'h1234_5678;
        bus.data_write = 1'b0;
        #1;
        chk("rw_next_cycle_new", bus.data_readdata, 32'h1234_5678);
        chk("run_cycles1", bus.cycle_count, 32'(run_cyc));

        // ---- Random stores with readback at a different byte offset ----
        for (int k = 0; k < 6; k++) begin
            wr_idx[k]          = int'($urandom_range(8, DW - 1));
            d                  = $urandom;
            bus.data_address   = DBASE + 32'(wr_idx[k]) * 4 + 32'($urandom_range(0, 3));
            bus.data_writedata = d;
            bus.data_write     = 1'b1;
            bus.data_read      = 1'b0;
            run_tick();
            dmem[wr_idx[k]]    = d;
            bus.data_write     = 1'b0;
            bus.data_read      = 1'b1;
            bus.data_address   = DBASE + 32'(wr_idx[k]) * 4 + 32'($urandom_range(0, 3));
            #1;
            chk("rand_store_readback", bus.data_readdata, exp_data(bus.data_address));
        end
        bus.data_read = 1'b0;
        chk("run_no_bus_error", bus.bus_error, 32'd0);

        // ---- Fetch outside the ROM window ----
        bus.instr_address = 32'h0000_0000;
        #1;
        chk("bad_fetch_data_zero", bus.instr_readdata, 32'h0);
        run_tick();
        chk("bad_fetch_bus_error", bus.bus_error, 32'd1);
        bus.instr_address = IBASE + 32'd2;
        #1;
        chk("misaligned_fetch_zero", bus.instr_readdata, 32'h0);
        bus.instr_address = IBASE;
        #1;
        chk("aligned_fetch_again", bus.instr_readdata, exp_instr(IBASE));

        // ---- Halt: active for 20 RUN cycles, then inactive ----
        while (run_cyc < 20) run_tick();
        chk("still_running", bus.halted, 32'd0);
        chk("cycles_before_halt", bus.cycle_count, 32'(run_cyc));
        bus.cpu_active = 1'b0;
        run_tick();
        chk("halt_halted",  bus.halted,         32'd1);
        chk("halt_clk_en",  bus.cpu_clk_enable, 32'd0);
        chk("halt_cpu_rst", bus.cpu_reset,      32'd0);
        chk("halt_timeout", bus.timeout,        32'd0);
        chk("halt_cycles",  bus.cycle_count,    32'(run_cyc));
        chk("halt_cycles_21", bus.cycle_count,  32'd21);

        // Stores outside RUN are ignored and the counter stays frozen.
        bus.data_address   = 32'h0000_0010;
        bus.data_writedata = 32'hFFFF_0000;
        bus.data_write     = 1'b1;
        tick();
        tick();
        bus.data_write = 1'b0;
        #1;
        chk("halt_write_ignored", bus.data_readdata, exp_data(32'h0000_0010));
        chk("halt_cycles_frozen", bus.cycle_count,   32'd21);
        chk("halt_sticky",        bus.halted,        32'd1);

        // ---- Reset from HALT, second run: memory persists ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("reset2");
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            bus.data_address = DBASE + 32'(wr_idx[k]) * 4;
            #1;
            chk("persist_rand_store", bus.data_readdata, exp_data(bus.data_address));
        end
        bus.data_address = 32'h0000_0010;
        #1;
        chk("persist_word4", bus.data_readdata, 32'h1234_5678);
        for (int i = 0; i < 5; i++) tick();
        chk("run2_no_spurious_halt", bus.halted, 32'd0);
        chk("run2_no_bus_error", bus.bus_error, 32'd0);

        // Store into the ROM window: dropped, flagged.
        bus.data_address   = IBASE;
        bus.data_writedata = 32'hFFFF_FFFF;
        bus.data_write     = 1'b1;
        tick();
        chk("rom_store_bus_error", bus.bus_error, 32'd1);
        // Store beyond the RAM window: dropped.
        bus.data_address = DBASE + DW * 4;
        tick();
        bus.data_write   = 1'b0;
        bus.data_address = 32'h0000_0000;
        #1;
        chk("bad_store_data0_kept", bus.data_readdata, 32'h00C0_FFEE);
        chk("rom_store_instr_kept", bus.instr_readdata, 32'h2402_0005);

        // ---- Reset in the middle of RUN ----
        a = bus.cycle_count;
        chk("run2_counting", 32'(a != 32'h0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("reset_mid_run");

        // ---- Out-of-range load wraps and flags ----
        do_load(1'b0, 32'(IW), 32'h0BAD_C0DE, 1'b0);
        chk("oob_load_bus_error", bus.bus_error, 32'd1);
        bus.instr_address = IBASE;
        #1;
        chk("oob_load_wrapped", bus.instr_readdata, 32'h0BAD_C0DE);
        bus.data_address = 32'h0000_0010;
        #1;
        chk("load3_persist_word4", bus.data_readdata, 32'h1234_5678);

        // ---- Timeout: CPU never goes inactive ----
        bus.load_done = 1'b1;
        tick();
        bus.load_done  = 1'b0;
        tick();
        bus.cpu_active = 1'b1;
        edges    = 0;
        got_halt = 1'b0;
        for (int i = 0; i < 4 * MAXC && !got_halt; i++) begin
            tick();
            edges++;
            if (bus.halted) got_halt = 1'b1;
        end
        chk("timeout_reached", 32'(got_halt), 32'd1);
        chk("timeout_flag",    bus.timeout,     32'd1);
        chk("timeout_cycles",  bus.cycle_count, 32'(MAXC));
        chk("timeout_edges",   32'(edges),      32'(MAXC));
        chk("timeout_clk_en",  bus.cpu_clk_enable, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
